calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Command sequencer on the reader side of the calculator's 4×4-bit `register_file`. It accepts one ALU command per handshake and fetches both operands through the file's single read port on successive cycles. It computes the result and writes it back through the write port. The write port commits on every clock edge, so this block owns that port outright.

## Interface
Parameters: none; widths fixed at 4-bit data, 2-bit address, 3-bit opcode.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command offered.
- `req_ready` out 1: command accepted when `req_valid && req_ready` at a rising edge.
- `req_op` in 3: opcode, see Operation.
- `req_src_a` in 2: operand A register.
- `req_src_b` in 2: operand B register.
- `req_dst` in 2: destination register.
- `rd_addr` out 2: to `register_file.rd_addr`.
- `rd_data` in 4: from `register_file.rd_data`; a combinational read of `rd_addr`.
- `we_addr` out 2: to `register_file.we_addr`.
- `we_data` out 4: to `register_file.we_data`.
- `done` out 1: one-cycle pulse after write-back.
- `result` out 4: last result, held until the next `done`.
- `flag_z` out 1 and `flag_c` out 1: present only with `CALC_FLAGS_EN`.

## Operation
- FSM states and transitions:
  - IDLE → READ_A on handshake.
  - READ_A → READ_B.
  - READ_B → EXEC.
  - EXEC → WRITE.
  - WRITE → IDLE.
- Handshake: `req_ready = (state==IDLE) && !rst`. The command fields are latched at the handshake.
- READ_A: `rd_addr=src_a`, and `rd_data` is latched into opA at the edge. READ_B does the same for src_b into opB. EXEC registers the ALU output.
- WRITE: `we_addr=dst`, `we_data=result_reg`, so the register file commits at the closing edge.
- Refresh rule: in every state other than WRITE, and in any cycle with `rst` high, drive `we_addr=rd_addr` and `we_data=rd_data`. The file rewrites its own value, so contents never change.
- Opcodes (all results mod 16):
  - 000 ADD.
  - 001 SUB: A−B, with carry = borrow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL A by 1: carry = A[3].
  - 111 SHR A by 1: carry = A[0].
  - Carry is 0 for the logic ops.
- src_a==src_b is legal: both reads return the same value.
- dst equal to a source is legal: the write follows both reads.

## Timing
- Handshake at edge 0. Reads occur in cycles 1–2, the result is registered at edge 3, and the write commits at edge 4.
- `done`=1 and `result`/flags update in cycle 5, while the FSM is in IDLE.
- `req_ready` is high in cycle 5, so the next command can be accepted in the same cycle as `done`.
- Throughput: one command per 5 cycles.
- A back-to-back command whose source is the previous dst reads the new value, because the write commits before the next READ_A.
- Reset values:
  - state IDLE.
  - `req_ready` 0 while `rst` high, 1 the cycle after.
  - `rd_addr` 0.
  - `done` 0, `result` 0, flags 0.
  - opA/opB/result_reg 0.
  - `we_addr`/`we_data` follow the refresh rule.
- Reset mid-operation, including in WRITE: the command is aborted with no write commit and no `done`.
- Register-file contents are not cleared by `rst`.

## Configuration
- `CALC_FLAGS_EN` defined:
  - `flag_z` (result==0) and `flag_c` (carry/borrow/shift-out) are registered alongside `result` and updated with `done`.
- Undefined:
  - The flag ports and their registers are absent, and carry is discarded.
  - All other behaviour is identical.

## Structure
- Package `calc_pkg`: opcode localparams or enum (ADD…SHR), FSM state enum, and width constants (DATA_W=4, ADDR_W=2, OP_W=3).
- Sub-module `calc_alu`: combinational, with inputs op, a, b and outputs y[3:0] and c. It is instantiated once and also reusable by the calculator top.

## Test plan
- Preload R0=3 and R1=5 by hierarchical deposit. ADD dst=R2 src 0,1 → `done` in cycle 5, `result`=8, R2=8, R0/R1 unchanged.
- R0=2, R1=5, SUB dst=R3 src 0,1 → `result`=13 (4'b1101); with `CALC_FLAGS_EN`, `flag_c`=1 and `flag_z`=0.
- Back-to-back commands:
  - First: R1=5, ADD R1←R1+R1.
  - Second: ADD R2←R1+R1, accepted in the first command's `done` cycle.
  - Expected: R1=10, then R2=4 with carry 1.
- Idle for 20 cycles with `rd_addr` sweeping all registers → every register is unchanged, confirming the refresh rule.
- Assert `rst` in the WRITE cycle of XOR R3←R0^R1 (R3 previously 7) → R3 stays 7, no `done`, `req_ready`=1 one cycle after `rst` deasserts.
- SHL R0=4'b1001 → `result`=4'b0010, `flag_c`=1. AND 4'b1010&4'b0101 → `result`=0, `flag_z`=1.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator datapath.
//   - Width constants DATA_W / ADDR_W / OP_W.
//   - ALU opcode encodings.
//   - Sequencer FSM state encodings.
// No ports; imported by calc_alu and calc_sequencer.
package calc_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int OP_W   = 3;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    // Sequencer FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ_A = 3'd1;
    localparam logic [2:0] ST_READ_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational 4-bit ALU.
// Ports:
//   op [2:0] in  - opcode (calc_pkg OP_*)
//   a  [3:0] in  - operand A
//   b  [3:0] in  - operand B
//   y  [3:0] out - result, modulo 16
//   c        out - carry for ADD, borrow for SUB, shifted-out bit for
//                  SHL/SHR, 0 for the logic ops
module calc_alu
    import calc_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              c
);

    // One extra bit so the top bit is the carry out / borrow out.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        c = 1'b0;
        case (op)
            OP_ADD: begin
                y = sum[DATA_W-1:0];
                c = sum[DATA_W];
            end
            OP_SUB: begin
                y = diff[DATA_W-1:0];
                c = diff[DATA_W];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = {a[DATA_W-2:0], 1'b0};
                c = a[DATA_W-1];
            end
            OP_SHR: begin
                y = {1'b0, a[DATA_W-1:1]};
                c = a[0];
            end
            default: begin
                y = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: fetches two operands from the 4x4 register file through
// its single read port, runs one ALU op and writes the result back.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_ready  - command handshake
//   req_op/src_a/src_b/dst - command fields, latched at the handshake
//   rd_addr / rd_data    - register file read port (combinational read)
//   we_addr / we_data    - register file write port (commits every edge)
//   done                 - one-cycle pulse after write-back
//   result               - last result, held until the next done
//   flag_z / flag_c      - zero and carry flags, only with CALC_FLAGS_EN
// Optional feature macro: CALC_FLAGS_EN.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_src_a,
    input  logic [ADDR_W-1:0] req_src_b,
    input  logic [ADDR_W-1:0] req_dst,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] we_addr,
    output logic [DATA_W-1:0] we_data,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef CALC_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    logic [2:0]        state_reg, state_next;
    logic [OP_W-1:0]   op_reg;
    logic [ADDR_W-1:0] src_a_reg, src_b_reg, dst_reg;
    logic [ADDR_W-1:0] sweep_reg;
    logic [DATA_W-1:0] op_a_reg, op_b_reg, result_reg;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;

    assign req_ready = (state_reg == ST_IDLE) && !rst;

    calc_alu u_alu (
        .op (op_reg),
        .a  (op_a_reg),
        .b  (op_b_reg),
        .y  (alu_y),
        .c  (alu_c)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = ST_READ_A;
            ST_READ_A: state_next = ST_READ_B;
            ST_READ_B: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WRITE;
            ST_WRITE:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outside the read cycles the read port walks through the file so the
    // refresh path below keeps rewriting every register with its own value.
    always_comb begin
        case (state_reg)
            ST_READ_A: rd_addr = src_a_reg;
            ST_READ_B: rd_addr = src_b_reg;
            default:   rd_addr = sweep_reg;
        endcase
    end

    // The file writes on every edge, so except for the write-back cycle the
    // port is fed the value just read, leaving the contents unchanged. rst
    // forces the refresh path so an aborted WRITE never commits.
    always_comb begin
        if ((state_reg == ST_WRITE) && !rst) begin
            we_addr = dst_reg;
            we_data = result_reg;
        end else begin
            we_addr = rd_addr;
            we_data = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            src_a_reg  <= '0;
            src_b_reg  <= '0;
            dst_reg    <= '0;
            sweep_reg  <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            result_reg <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_reg + 1'b1;
            done      <= 1'b0;
            if (req_valid && req_ready) begin
                op_reg    <= req_op;
                src_a_reg <= req_src_a;
                src_b_reg <= req_src_b;
                dst_reg   <= req_dst;
            end
            case (state_reg)
                ST_READ_A: op_a_reg   <= rd_data;
                ST_READ_B: op_b_reg   <= rd_data;
                ST_EXEC:   result_reg <= alu_y;
                ST_WRITE: begin
                    done   <= 1'b1;
                    result <= result_reg;
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_FLAGS_EN
    logic carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            if (state_reg == ST_EXEC) carry_reg <= alu_c;
            if (state_reg == ST_WRITE) begin
                flag_z <= (result_reg == '0);
                flag_c <= carry_reg;
            end
        end
    end
`else
    // Carry has no consumer without the flag registers.
    logic unused_carry;
    assign unused_carry = alu_c;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a behavioural
// register file and an integer reference model of the calculator.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [1:0] req_src_a, req_src_b, req_dst;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic [1:0] we_addr;
    logic [3:0] we_data;
    logic       done;
    logic [3:0] result;
`ifdef CALC_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src_a (req_src_a),
        .req_src_b (req_src_b),
        .req_dst   (req_dst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .we_addr   (we_addr),
        .we_data   (we_data),
        .done      (done),
        .result    (result)
`ifdef CALC_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_c    (flag_c)
`endif
    );

    // Behavioural register file: combinational read, write on every edge.
    // A bench deposit lands after the port write so it wins.
    logic [3:0] mem [4];
    logic       dep_valid = 1'b0;
    logic [1:0] dep_addr  = '0;
    logic [3:0] dep_data  = '0;

    assign rd_data = mem[rd_addr];

    always @(posedge clk) begin
        mem[we_addr] <= we_data;
        if (dep_valid) mem[dep_addr] <= dep_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state and scoreboard
    int model [4];

    typedef struct {
        int op;
        int res;
        int z;
        int c;
        int d;
        int cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_hs  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input int op, input int a, input int b,
                                     output int r, output int c);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b; r = s % 16; c = (s > 15) ? 1 : 0; end
            1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
            default: begin r = a / 2; c = a % 2; end
        endcase
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic deposit(input int a, input int v);
        dep_valid = 1'b1;
        dep_addr  = 2'(a);
        dep_data  = 4'(v);
        model[a]  = v;
        @(posedge clk);
        @(negedge clk);
        dep_valid = 1'b0;
    endtask

    // Called at a negedge. commit=0 means the command will be aborted by
    // reset, so it neither updates the model nor expects a done.
    task automatic issue(input int op, input int a, input int b, input int d, input bit commit);
        int waited = 0;
        int r, c;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready stuck at 0 for %0d cycles", waited);
            return;
        end
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_src_a = 2'(a);
        req_src_b = 2'(b);
        req_dst   = 2'(d);
        last_hs   = cyc;
        if (commit) begin
            ref_calc(op, model[a], model[b], r, c);
            model[d] = r;
            sb_q.push_back('{op: op, res: r, z: (r == 0) ? 1 : 0, c: c, d: d, cyc: cyc});
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_file(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_R%0d", tag, i), 32'(mem[i]), 32'(model[i]));
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: done=1 with no command outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn op=%0d dst=R%0d result=%0d expected=%0d cycle=%0d",
                         e.op, e.d, result, e.res, cyc - e.cyc);
                check("result", 32'(result), 32'(e.res));
                check("done_latency", 32'(cyc - e.cyc), 32'd5);
                check("writeback", 32'(mem[e.d]), 32'(e.res));
`ifdef CALC_FLAGS_EN
                check("flag_z", 32'(flag_z), 32'(e.z));
                check("flag_c", 32'(flag_c), 32'(e.c));
`endif
            end
        end
    end

    initial begin
        int hs_first;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_src_a = '0;
        req_src_b = '0;
        req_dst   = '0;

        // Reset with the file preloaded
        @(negedge clk);
        for (int i = 0; i < 4; i++) deposit(i, int'($urandom_range(0, 15)));
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_we_addr", 32'(we_addr), 32'd0);
        check("rst_we_data", 32'(we_data), 32'(model[0]));
`ifdef CALC_FLAGS_EN
        check("rst_flag_z", 32'(flag_z), 32'd0);
        check("rst_flag_c", 32'(flag_c), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check_file("post_rst");

        // ADD R2 <- R0 + R1 with R0=3, R1=5
        deposit(0, 3);
        deposit(1, 5);
        issue(0, 0, 1, 2, 1'b1);
        drain();
        check("add_R2", 32'(mem[2]), 32'd8);
        check_file("add");

        // SUB R3 <- R0 - R1 with R0=2, R1=5
        deposit(0, 2);
        issue(1, 0, 1, 3, 1'b1);
        drain();
        check("sub_R3", 32'(mem[3]), 32'd13);

        // Back-to-back: R1 <- R1+R1, then R2 <- R1+R1 in the done cycle
        deposit(1, 5);
        issue(0, 1, 1, 1, 1'b1);
        hs_first = last_hs;
        issue(0, 1, 1, 2, 1'b1);
        check("b2b_spacing", 32'(last_hs - hs_first), 32'd5);
        drain();
        check("b2b_R1", 32'(mem[1]), 32'd10);
        check("b2b_R2", 32'(mem[2]), 32'd4);

        // Idle: contents must survive the refresh writes
        repeat (20) @(negedge clk);
        check_file("idle");

        // Reset during the WRITE cycle of XOR R3 <- R0 ^ R1
        deposit(3, 7);
        issue(4, 0, 1, 3, 1'b0);       // returns mid READ_A (cycle 1)
        repeat (3) @(negedge clk);     // mid WRITE (cycle 4)
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_in_rst", 32'(req_ready), 32'd0);
        check("abort_done_c5", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_done_c6", 32'(done), 32'd0);
        check("abort_R3", 32'(mem[3]), 32'd7);
        check_file("abort");

        // SHL 4'b1001 and AND 4'b1010 & 4'b0101
        deposit(0, 9);
        issue(6, 0, 1, 2, 1'b1);
        drain();
        deposit(0, 10);
        deposit(1, 5);
        issue(2, 0, 1, 3, 1'b1);
        drain();

        // Randomized commands with random gaps and occasional deposits
        for (int n = 0; n < 60; n++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if (n % 15 == 14) begin
                drain();
                check_file("rand");
                deposit(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            end
        end
        drain();
        check_file("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
